vram_dp_fill: RTL and testbench
===============================

# vram_dp_fill

Parametrised dual-port video RAM with a hardware fill engine, the successor to the fixed 2 KB text VRAM. One port serves the CPU with read/write and a ready handshake. The other serves the video fetch path read-only, with a valid strobe. A built-in fill engine clears or fills a contiguous address range at one word per clock, for screen clear and attribute fill. It sits between the CPU bus decode and the CRTC/video fetch logic, all in the single system clock domain.

## Interface
Parameters:
- DW, 8, data width in bits
- AW, 11, address width; depth = 2**AW words

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- CCS  in  1  CPU port select
- CWE  in  1  CPU write request (qualified by CCS)
- CRD  in  1  CPU read request (qualified by CCS)
- CA  in  AW  CPU address
- CDI  in  DW  CPU write data
- CDO  out  DW  CPU read data, registered
- CVLD  out  1  one-cycle pulse: CDO updated
- CRDY  out  1  CPU request accepted this cycle (combinational)
- VRD  in  1  video read request
- VA  in  AW  video address
- VDO  out  DW  video read data, registered
- VVLD  out  1  one-cycle pulse: VDO updated
- FILL_START  in  1  start fill (pulse, sampled in IDLE only)
- FILL_ABORT  in  1  stop an active fill
- FILL_BASE  in  AW  first fill address
- FILL_LEN  in  AW+1  word count, 0..2**AW
- FILL_DATA  in  DW  fill pattern
- FILL_BUSY  out  1  fill in progress
- FILL_DONE  out  1  one-cycle pulse at normal completion

## Operation
- Storage: 2**AW × DW array. There is one write path, shared by the CPU and the fill engine. There are two independent read paths, CPU and video.
- Reset clears CDO=0, CVLD=0, VDO=0, VVLD=0, FILL_BUSY=0, FILL_DONE=0, sets the FSM to IDLE, and clears the fill pointer and counter. Memory contents are not cleared.
- CRDY = !(CCS & CWE & FILL_BUSY). CRDY reads 1 during reset.
- CPU write: on CCS & CWE & CRDY, ram[CA] <= CDI. No CVLD is generated.
- CPU read: on CCS & CRD & !CWE, CDO <= ram[CA] and CVLD=1 on the next cycle. CPU reads are never stalled.
- CWE and CRD both high: the request is treated as a write only.
- A stalled CPU write (CRDY=0) must be held by the CPU until CRDY=1. The block does not queue it.
- Video read: on VRD, VDO <= ram[VA] and VVLD=1 on the next cycle. It is never stalled and has no interaction with the CPU or the fill engine.
- CDO and VDO hold their last value when no read occurs.
- Read-during-write to the same address, from either read port: the read returns the old data (read-first).
- FSM states: IDLE, FILL, DONE.
- IDLE: on FILL_START with FILL_LEN≠0, load ptr=FILL_BASE and cnt=FILL_LEN, then go to FILL.
- IDLE: on FILL_START with FILL_LEN=0, go directly to DONE. No writes are made.
- FILL, each cycle: ram[ptr] <= FILL_DATA, ptr <= ptr+1 mod 2**AW (wraps from 2**AW−1 to 0), cnt <= cnt−1. When cnt=1, the last write occurs and the FSM goes to DONE.
- FILL with FILL_ABORT high: no write in that cycle, go to IDLE, and no FILL_DONE pulse. Abort has priority over the write.
- DONE: lasts one cycle, then goes to IDLE.
- FILL_START outside IDLE is ignored. FILL_ABORT outside FILL is ignored.
- FILL_BASE, FILL_LEN and FILL_DATA are sampled at start only. FILL_DATA is captured into a register.
- FILL_LEN=2**AW fills the whole array exactly once.

## Timing
- CPU read and video read latency: 1 clock from the request edge to CDO/VDO and CVLD/VVLD.
- CPU write latency: the write is visible to a read issued on the next cycle.
- Fill: FILL_START is sampled at edge T0.
  - FILL_BUSY=1 during cycles T0+1 .. T0+N; one word is written per cycle.
  - FILL_DONE=1 during cycle T0+N+1.
  - FILL_BUSY=0 in DONE.
  - Zero length: FILL_DONE=1 during T0+1 and FILL_BUSY stays 0.
- FILL_BUSY and FILL_DONE are registered, decoded from the state register.
- CRDY falls in the same cycle FILL_BUSY rises. A held write is accepted in the DONE cycle at the earliest.
- RST_N low during a fill: the FSM goes to IDLE immediately (asynchronous). Words already written remain, and no FILL_DONE pulse is generated.

## Test plan
- CPU write then read, AW=11, DW=8: write 0x5A to 0x123, then read 0x123. Expected: CDO=0x5A with CVLD one cycle after the read. A simultaneous VRD of VA=0x123 gives VDO=0x5A and VVLD.
- Fill with BASE=0x7FE, LEN=4, DATA=0x20. Expected: addresses 0x7FE, 0x7FF, 0x000, 0x001 read back 0x20; 0x7FD and 0x002 are unchanged; BUSY is high for exactly 4 cycles and DONE pulses once.
- CPU write during a fill (LEN=8), write 0xAA to 0x010 at busy cycle 2. Expected: CRDY=0 until the DONE cycle, then the write lands. A CPU read issued during the fill completes with 1-cycle latency.
- LEN=0 and LEN=2048 with DATA=0xFF. Expected: LEN=0 pulses DONE at T0+1 with no writes and BUSY never high; LEN=2048 gives BUSY for 2048 cycles and all words read 0xFF.
- Abort on the 3rd busy cycle of LEN=10 at BASE=0. Expected: exactly addresses 0..1 are filled, there is no DONE pulse, and the FSM returns to IDLE. A FILL_START issued during busy is ignored.
- Reset: assert RST_N=0 mid-fill and during CVLD/VVLD. Expected: all outputs go to their reset values immediately and CRDY=1. Same-cycle write/read of one address returns the old data.

Source files
------------

// File: rtl/vram_dp_fill_if.sv
// ----------------------------------------------------------------------------
// vram_dp_fill_if
//
// Bundles the CPU port, the video fetch port and the fill-engine control of
// vram_dp_fill into one interface. The clock and reset stay outside as plain
// ports on the RAM itself.
//
//   CPU port   : CCS, CWE, CRD, CA, CDI  ->  CDO, CVLD, CRDY
//   Video port : VRD, VA                 ->  VDO, VVLD
//   Fill ctrl  : FILL_START, FILL_ABORT, FILL_BASE, FILL_LEN, FILL_DATA
//                                        ->  FILL_BUSY, FILL_DONE
//
// Modports:
//   master : the requesting side (bus decode / CRTC / fill control)
//   slave  : the VRAM block
// ----------------------------------------------------------------------------
interface vram_dp_fill_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 11
);

    // CPU port
    logic          CCS;
    logic          CWE;
    logic          CRD;
    logic [AW-1:0] CA;
    logic [DW-1:0] CDI;
    logic [DW-1:0] CDO;
    logic          CVLD;
    logic          CRDY;

    // Video fetch port
    logic          VRD;
    logic [AW-1:0] VA;
    logic [DW-1:0] VDO;
    logic          VVLD;

    // Fill engine; FILL_LEN is one bit wider so a full-array fill fits
    logic          FILL_START;
    logic          FILL_ABORT;
    logic [AW-1:0] FILL_BASE;
    logic [AW:0]   FILL_LEN;
    logic [DW-1:0] FILL_DATA;
    logic          FILL_BUSY;
    logic          FILL_DONE;

    modport master (
        output CCS, CWE, CRD, CA, CDI,
        input  CDO, CVLD, CRDY,
        output VRD, VA,
        input  VDO, VVLD,
        output FILL_START, FILL_ABORT, FILL_BASE, FILL_LEN, FILL_DATA,
        input  FILL_BUSY, FILL_DONE
    );

    modport slave (
        input  CCS, CWE, CRD, CA, CDI,
        output CDO, CVLD, CRDY,
        input  VRD, VA,
        output VDO, VVLD,
        input  FILL_START, FILL_ABORT, FILL_BASE, FILL_LEN, FILL_DATA,
        output FILL_BUSY, FILL_DONE
    );

endinterface

// File: rtl/vram_dp_fill.sv
// ----------------------------------------------------------------------------
// vram_dp_fill
//
// Dual-port video RAM (2**AW words of DW bits) with a built-in fill engine.
//
//   CLK    : system clock, everything on the rising edge
//   RST_N  : asynchronous active-low reset (memory contents are kept)
//   bus    : vram_dp_fill_if.slave
//            - CPU port: read/write, registered read data, CRDY stalls
//              writes while the fill engine owns the write path
//            - video port: read-only, registered read data, never stalled
//            - fill engine: writes FILL_DATA to FILL_LEN consecutive words
//              starting at FILL_BASE, one word per clock, wrapping at the
//              top of the array
//
// Both read ports return the old word when the same address is written in
// the same cycle (read-first).
// ----------------------------------------------------------------------------
module vram_dp_fill #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 11
) (
    input logic           CLK,
    input logic           RST_N,
    vram_dp_fill_if.slave bus
);

    localparam int unsigned Depth  = 2 ** AW;
    localparam logic [AW-1:0] PtrOne = 1;
    localparam logic [AW:0]   CntOne = 1;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StDone
    } state_e;

    // ------------------------------------------------------------------
    // Fill engine state
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] pat_q, pat_d;
    logic          fill_we;

    // ------------------------------------------------------------------
    // Storage and port registers
    // ------------------------------------------------------------------
    logic [DW-1:0] mem [Depth];

    logic [DW-1:0] cdo_q;
    logic          cvld_q;
    logic [DW-1:0] vdo_q;
    logic          vvld_q;

    logic          fill_busy;
    logic          cpu_wr_req;
    logic          cpu_we;
    logic          cpu_re;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;

    // Busy/done come straight from the state register so they are glitch-free
    // and drop to zero the moment reset is asserted.
    assign fill_busy     = (state_q == StFill);
    assign bus.FILL_BUSY = fill_busy;
    assign bus.FILL_DONE = (state_q == StDone);

    // ------------------------------------------------------------------
    // CPU handshake: only a write can stall, and only against the fill.
    // ------------------------------------------------------------------
    assign cpu_wr_req = bus.CCS & bus.CWE;
    assign bus.CRDY   = ~(cpu_wr_req & fill_busy);
    assign cpu_we     = cpu_wr_req & bus.CRDY;
    // A simultaneous CWE/CRD is a write; the read half is dropped.
    assign cpu_re     = bus.CCS & bus.CRD & ~bus.CWE;

    // ------------------------------------------------------------------
    // Fill FSM, next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        fill_we = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.FILL_START) begin
                    if (bus.FILL_LEN == '0) begin
                        // Zero-length request still reports completion.
                        state_d = StDone;
                    end else begin
                        state_d = StFill;
                        ptr_d   = bus.FILL_BASE;
                        cnt_d   = bus.FILL_LEN;
                        pat_d   = bus.FILL_DATA;
                    end
                end
            end

            StFill: begin
                if (bus.FILL_ABORT) begin
                    // Abort wins over the write scheduled for this cycle.
                    state_d = StIdle;
                end else begin
                    fill_we = 1'b1;
                    ptr_d   = ptr_q + PtrOne;  // wraps naturally at 2**AW
                    cnt_d   = cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        state_d = StDone;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fill FSM, state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
        end
    end

    // ------------------------------------------------------------------
    // Single write path. The fill and the CPU can never both write in one
    // cycle: the fill only writes while busy, and CRDY blocks the CPU then.
    // ------------------------------------------------------------------
    assign mem_we = fill_we | cpu_we;
    assign mem_wa = fill_we ? ptr_q : bus.CA;
    assign mem_wd = fill_we ? pat_q : bus.CDI;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // ------------------------------------------------------------------
    // CPU read port: non-blocking read of mem gives read-first behaviour.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cdo_q  <= '0;
            cvld_q <= 1'b0;
        end else begin
            cvld_q <= cpu_re;
            if (cpu_re) begin
                cdo_q <= mem[bus.CA];
            end
        end
    end

    // ------------------------------------------------------------------
    // Video read port: fully independent of the CPU and the fill engine.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vdo_q  <= '0;
            vvld_q <= 1'b0;
        end else begin
            vvld_q <= bus.VRD;
            if (bus.VRD) begin
                vdo_q <= mem[bus.VA];
            end
        end
    end

    assign bus.CDO  = cdo_q;
    assign bus.CVLD = cvld_q;
    assign bus.VDO  = vdo_q;
    assign bus.VVLD = vvld_q;

    // ------------------------------------------------------------------
    // Structural sanity checks
    // ------------------------------------------------------------------
    a_single_writer : assert property (@(posedge CLK) disable iff (!RST_N)
        !(fill_we && cpu_we));

    a_busy_done_excl : assert property (@(posedge CLK) disable iff (!RST_N)
        !(bus.FILL_BUSY && bus.FILL_DONE));

endmodule

// File: tb/tb_vram_dp_fill.sv
// ----------------------------------------------------------------------------
// tb_vram_dp_fill
//
// Directed scenarios followed by randomized traffic, all checked cycle by
// cycle against a behavioural model: a plain word array for the memory and a
// timeline description of the fill (start cycle, length, abort) from which
// the expected busy/done windows and written addresses are computed.
// ----------------------------------------------------------------------------
module tb_vram_dp_fill;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 11;
    localparam int unsigned Depth = 1 << AW;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    always #5 CLK = ~CLK;

    vram_dp_fill_if #(.DW(DW), .AW(AW)) bus ();

    vram_dp_fill #(.DW(DW), .AW(AW)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [DW-1:0] m_mem [Depth];
    bit            f_on;
    int            f_t0;       // cycle in which the start was sampled
    int            f_n;        // requested word count
    logic [AW-1:0] f_base;
    logic [DW-1:0] f_data;
    int            done_cyc;   // cycle in which FILL_DONE is expected, -1 if none
    logic [DW-1:0] e_cdo, e_vdo;
    bit            e_cvld, e_vvld;

    // Values seen just before the last edge, for the directed tests.
    bit s_busy, s_done, s_crdy;

    function automatic bit m_busy(int c);
        return f_on && (c > f_t0) && (c <= f_t0 + f_n);
    endfunction

    task automatic model_reset();
        f_on     = 1'b0;
        f_t0     = 0;
        f_n      = 0;
        done_cyc = -1;
        e_cdo    = '0;
        e_vdo    = '0;
        e_cvld   = 1'b0;
        e_vvld   = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.CCS        = 1'b0;
        bus.CWE        = 1'b0;
        bus.CRD        = 1'b0;
        bus.CA         = '0;
        bus.CDI        = '0;
        bus.VRD        = 1'b0;
        bus.VA         = '0;
        bus.FILL_START = 1'b0;
        bus.FILL_ABORT = 1'b0;
        bus.FILL_BASE  = '0;
        bus.FILL_LEN   = '0;
        bus.FILL_DATA  = '0;
    endtask

    // One clock cycle with the inputs currently applied: check outputs,
    // advance the model across the edge, then step the clock.
    task automatic tick();
        bit            busy, done, idle;
        logic [AW-1:0] fa;
        #1;
        busy = m_busy(cyc);
        done = (cyc == done_cyc);
        idle = !busy && !done;

        check_eq("crdy", bus.CRDY, !(bus.CCS && bus.CWE && busy));
        check_eq("fill_busy", bus.FILL_BUSY, busy);
        check_eq("fill_done", bus.FILL_DONE, done);
        check_eq("cvld", bus.CVLD, e_cvld);
        check_eq("cdo", bus.CDO, e_cdo);
        check_eq("vvld", bus.VVLD, e_vvld);
        check_eq("vdo", bus.VDO, e_vdo);
        s_busy = bus.FILL_BUSY;
        s_done = bus.FILL_DONE;
        s_crdy = bus.CRDY;

        // Reads see memory before this cycle's write.
        e_cvld = bus.CCS && bus.CRD && !bus.CWE;
        if (e_cvld) e_cdo = m_mem[bus.CA];
        e_vvld = bus.VRD;
        if (e_vvld) e_vdo = m_mem[bus.VA];

        if (busy) begin
            if (bus.FILL_ABORT) begin
                f_on     = 1'b0;
                done_cyc = -1;
            end else begin
                fa        = f_base + AW'(cyc - f_t0 - 1);
                m_mem[fa] = f_data;
            end
        end
        if (bus.CCS && bus.CWE && !busy) m_mem[bus.CA] = bus.CDI;

        if (idle && bus.FILL_START) begin
            if (bus.FILL_LEN == '0) begin
                done_cyc = cyc + 1;
            end else begin
                f_on     = 1'b1;
                f_t0     = cyc;
                f_n      = int'(bus.FILL_LEN);
                f_base   = bus.FILL_BASE;
                f_data   = bus.FILL_DATA;
                done_cyc = cyc + f_n + 1;
            end
        end

        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.CCS = 1'b1; bus.CWE = 1'b1; bus.CRD = 1'b0; bus.CA = a; bus.CDI = d;
        tick();
        bus.CCS = 1'b0; bus.CWE = 1'b0;
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        bus.CCS = 1'b1; bus.CWE = 1'b0; bus.CRD = 1'b1; bus.CA = a;
        tick();
        bus.CCS = 1'b0; bus.CRD = 1'b0;
        d = bus.CDO;
    endtask

    task automatic run_fill(input logic [AW-1:0] base, input int len, input logic [DW-1:0] data,
                            output int nb, output int nd);
        bus.FILL_BASE  = base;
        bus.FILL_LEN   = (AW+1)'(len);
        bus.FILL_DATA  = data;
        bus.FILL_START = 1'b1;
        tick();
        bus.FILL_START = 1'b0;
        nb = 0;
        nd = 0;
        for (int i = 0; i < len + 3; i++) begin
            tick();
            nb += int'(s_busy);
            nd += int'(s_done);
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset();
        RST_N   = 1'b0;
        bus.CCS = 1'b1;
        bus.CWE = 1'b1;
        #1;
        check_eq("rst cdo", bus.CDO, 0);
        check_eq("rst cvld", bus.CVLD, 0);
        check_eq("rst vdo", bus.VDO, 0);
        check_eq("rst vvld", bus.VVLD, 0);
        check_eq("rst busy", bus.FILL_BUSY, 0);
        check_eq("rst done", bus.FILL_DONE, 0);
        check_eq("rst crdy", bus.CRDY, 1);
        idle_inputs();
        @(posedge CLK);
        #1;
        cyc++;
        RST_N = 1'b1;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [DW-1:0] rd;
        int            nb, nd, bad_words, stall;
        bit            acc;

        for (int i = 0; i < Depth; i++) m_mem[i] = '0;
        model_reset();
        idle_inputs();

        // Power-on reset
        do_reset();

        // Full-array fill gives the whole memory a known value.
        run_fill(AW'(0), Depth, 8'hFF, nb, nd);
        check_eq("full fill busy cycles", nb, Depth);
        check_eq("full fill done pulses", nd, 1);
        bad_words = 0;
        for (int a = 0; a < Depth; a += 2) begin
            bus.CCS = 1'b1; bus.CRD = 1'b1; bus.CA = AW'(a);
            bus.VRD = 1'b1; bus.VA = AW'(a + 1);
            tick();
            bad_words += int'(bus.CDO != 8'hFF) + int'(bus.VDO != 8'hFF);
        end
        idle_inputs();
        check_eq("full fill words not FF", bad_words, 0);

        // CPU write then read, with a simultaneous video read.
        cpu_write(11'h123, 8'h5A);
        bus.CCS = 1'b1; bus.CRD = 1'b1; bus.CA = 11'h123;
        bus.VRD = 1'b1; bus.VA = 11'h123;
        tick();
        idle_inputs();
        check_eq("wr/rd cdo", bus.CDO, 8'h5A);
        check_eq("wr/rd cvld", bus.CVLD, 1);
        check_eq("wr/rd vdo", bus.VDO, 8'h5A);
        check_eq("wr/rd vvld", bus.VVLD, 1);

        // Wrapping fill at the top of the array.
        cpu_write(11'h7FD, 8'h11);
        cpu_write(11'h002, 8'h22);
        run_fill(11'h7FE, 4, 8'h20, nb, nd);
        check_eq("wrap busy cycles", nb, 4);
        check_eq("wrap done pulses", nd, 1);
        cpu_read(11'h7FD, rd); check_eq("wrap 7FD", rd, 8'h11);
        cpu_read(11'h7FE, rd); check_eq("wrap 7FE", rd, 8'h20);
        cpu_read(11'h7FF, rd); check_eq("wrap 7FF", rd, 8'h20);
        cpu_read(11'h000, rd); check_eq("wrap 000", rd, 8'h20);
        cpu_read(11'h001, rd); check_eq("wrap 001", rd, 8'h20);
        cpu_read(11'h002, rd); check_eq("wrap 002", rd, 8'h22);

        // CPU read and held CPU write during a fill of 8.
        bus.FILL_BASE = 11'h100; bus.FILL_LEN = 12'd8; bus.FILL_DATA = 8'h5C;
        bus.FILL_START = 1'b1;
        tick();
        bus.FILL_START = 1'b0;
        bus.CCS = 1'b1; bus.CRD = 1'b1; bus.CA = 11'h123;
        tick();
        check_eq("rd in fill cvld", bus.CVLD, 1);
        check_eq("rd in fill cdo", bus.CDO, 8'h5A);
        bus.CRD = 1'b0; bus.CWE = 1'b1; bus.CA = 11'h010; bus.CDI = 8'hAA;
        acc   = 1'b0;
        stall = 0;
        for (int i = 0; i < 20 && !acc; i++) begin
            tick();
            if (s_crdy) begin
                acc = 1'b1;
                check_eq("held wr in done cycle", s_done, 1);
            end else begin
                stall++;
            end
        end
        idle_inputs();
        check_eq("held wr accepted", acc, 1);
        check_eq("held wr stall cycles", stall, 7);
        cpu_read(11'h010, rd); check_eq("held wr data", rd, 8'hAA);

        // Zero-length fill.
        cpu_write(11'h050, 8'h3C);
        run_fill(11'h050, 0, 8'hFF, nb, nd);
        check_eq("len0 busy cycles", nb, 0);
        check_eq("len0 done pulses", nd, 1);
        cpu_read(11'h050, rd); check_eq("len0 no write", rd, 8'h3C);

        // Abort on the 3rd busy cycle; a start during busy is ignored.
        for (int a = 0; a < 4; a++) cpu_write(AW'(a), 8'h00);
        bus.FILL_BASE = 11'h000; bus.FILL_LEN = 12'd10; bus.FILL_DATA = 8'h33;
        bus.FILL_START = 1'b1;
        tick();
        bus.FILL_START = 1'b0;
        tick();
        bus.FILL_START = 1'b1; bus.FILL_BASE = 11'h400; bus.FILL_LEN = 12'd5;
        tick();
        bus.FILL_START = 1'b0;
        bus.FILL_ABORT = 1'b1;
        tick();
        bus.FILL_ABORT = 1'b0;
        nd = 0;
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            nd += int'(s_done);
            nb += int'(s_busy);
        end
        check_eq("abort done pulses", nd, 0);
        check_eq("abort busy after", nb, 0);
        cpu_read(11'h000, rd); check_eq("abort 000", rd, 8'h33);
        cpu_read(11'h001, rd); check_eq("abort 001", rd, 8'h33);
        cpu_read(11'h002, rd); check_eq("abort 002", rd, 8'h00);
        cpu_read(11'h003, rd); check_eq("abort 003", rd, 8'h00);

        // Read-during-write returns old data on both read ports.
        cpu_write(11'h200, 8'h10);
        bus.CCS = 1'b1; bus.CWE = 1'b1; bus.CA = 11'h200; bus.CDI = 8'h99;
        bus.VRD = 1'b1; bus.VA = 11'h200;
        tick();
        idle_inputs();
        check_eq("rdw video old", bus.VDO, 8'h10);
        cpu_write(11'h201, 8'h31);
        bus.FILL_BASE = 11'h201; bus.FILL_LEN = 12'd1; bus.FILL_DATA = 8'hEE;
        bus.FILL_START = 1'b1;
        tick();
        bus.FILL_START = 1'b0;
        cpu_read(11'h201, rd); check_eq("rdw cpu old", rd, 8'h31);
        cpu_read(11'h201, rd); check_eq("rdw cpu new", rd, 8'hEE);

        // Reset mid-fill with read strobes pending.
        bus.FILL_BASE = 11'h300; bus.FILL_LEN = 12'd20; bus.FILL_DATA = 8'h44;
        bus.FILL_START = 1'b1;
        tick();
        bus.FILL_START = 1'b0;
        repeat (5) tick();
        bus.CCS = 1'b1; bus.CRD = 1'b1; bus.CA = 11'h123;
        bus.VRD = 1'b1; bus.VA = 11'h123;
        tick();
        idle_inputs();
        check_eq("pre-rst cvld", bus.CVLD, 1);
        do_reset();
        tick();
        cpu_read(11'h300, rd); check_eq("rst kept 300", rd, 8'h44);
        cpu_read(11'h314, rd); check_eq("rst untouched 314", rd, 8'hFF);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bus.CCS = ($urandom_range(0, 99) < 60);
            bus.CWE = ($urandom_range(0, 2) == 0);
            bus.CRD = $urandom_range(0, 1) != 0;
            bus.CA  = $urandom_range(0, 1) != 0 ? AW'($urandom_range(0, 15)) : AW'($urandom);
            bus.CDI = DW'($urandom);
            bus.VRD = $urandom_range(0, 1) != 0;
            bus.VA  = $urandom_range(0, 1) != 0 ? AW'($urandom_range(0, 15)) : AW'($urandom);
            bus.FILL_START = ($urandom_range(0, 19) == 0);
            bus.FILL_ABORT = ($urandom_range(0, 39) == 0);
            bus.FILL_BASE  = $urandom_range(0, 1) != 0 ? AW'($urandom_range(0, 15)) : AW'($urandom);
            case ($urandom_range(0, 9))
                0:       bus.FILL_LEN = '0;
                1:       bus.FILL_LEN = (AW+1)'($urandom_range(0, Depth));
                default: bus.FILL_LEN = (AW+1)'($urandom_range(1, 24));
            endcase
            bus.FILL_DATA = DW'($urandom);
            tick();
        end
        idle_inputs();
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
